// File: rtl/rsp_s2_dma_pkg.sv
// Shared types for the DMA AXI channel watchdog: per-channel FSM encoding,
// channel index constants and a lowest-set-bit helper used by timeout capture.
package rsp_s2_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } wdog_state_e;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  // Scans from the top down so the lowest set index is the one left standing.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rsp_s2_dma_axi_wdog_ch.sv
// One watchdog channel: counts consecutive stalled cycles and raises a sticky
// timeout flag on the edge that completes timeout_limit stalled cycles.
module rsp_s2_dma_axi_wdog_ch
  import rsp_s2_dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stalled,
  input  logic [CNT_W-1:0] limit,
  input  logic             clr,
  output logic             set,
  output logic             sts
);

  wdog_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_m1;

  // Only meaningful while stalled, which already implies limit != 0.
  assign lim_m1 = limit - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (stalled) begin
          cnt_d = CNT_W'(1);
          if (limit == CNT_W'(1)) begin
            state_d = ST_EXPIRED;
            set     = 1'b1;
          end else begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        if (!stalled) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= lim_m1) begin
          // Also catches a limit lowered below the running count.
          state_d = ST_EXPIRED;
          set     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EXPIRED: begin
        if (!stalled) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sts     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sts     <= set | (sts & ~clr);
    end
  end

endmodule

// File: rtl/rsp_s2_dma_axi_wdog.sv
// AXI VALID/READY stall watchdog over NUM_CH channels with sticky status and level irq.
// Optional first-timeout capture when RSP_S2_DMA_WDOG_CAPTURE_EN is defined.
module rsp_s2_dma_axi_wdog
  import rsp_s2_dma_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] valid,
  input  logic [NUM_CH-1:0] ready,
  input  logic [CNT_W-1:0]  timeout_limit,
  input  logic [NUM_CH-1:0] clr,
  input  logic [NUM_CH-1:0] irq_mask,
  output logic [NUM_CH-1:0] timeout_sts,
  output logic              timeout_irq,
  output logic              first_vld,
  output logic [3:0]        first_ch
);

  logic [NUM_CH-1:0] stalled;
  logic [NUM_CH-1:0] set_vec;

  assign stalled = {NUM_CH{en & (|timeout_limit)}} & valid & ~ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rsp_s2_dma_axi_wdog_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .stalled (stalled[i]),
      .limit   (timeout_limit),
      .clr     (clr[i]),
      .set     (set_vec[i]),
      .sts     (timeout_sts[i])
    );
  end

  assign timeout_irq = |(timeout_sts & ~irq_mask);

`ifdef RSP_S2_DMA_WDOG_CAPTURE_EN
  logic [15:0] set_vec16;
  assign set_vec16 = 16'(set_vec);

  // A set landing while status is empty starts a fresh record rather than
  // being lost to the pending clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_vld <= 1'b0;
      first_ch  <= 4'd0;
    end else if ((!first_vld || ~|timeout_sts) && (|set_vec)) begin
      first_vld <= 1'b1;
      first_ch  <= lowest_idx(set_vec16);
    end else if (~|timeout_sts) begin
      first_vld <= 1'b0;
    end
  end
`else
  logic unused_set;
  assign unused_set = ^set_vec;
  assign first_vld  = 1'b0;
  assign first_ch   = 4'd0;
`endif

endmodule

// File: doc/rsp_s2_dma_axi_wdog.md
RSP_S2_DMA_AXI_WDOG -- requirements
Module: rsp_s2_dma_axi_wdog

Interface
REQ-001 Parameter NUM_CH, default 5, is the number of monitored VALID/READY channels (AW,W,B,AR,R order), legal range 1..16.
REQ-002 Parameter CNT_W, default 16, is the stall counter and timeout limit width, legal range 4..32.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global monitor enable.
REQ-006 valid  input  NUM_CH  per-channel VALID.
REQ-007 ready  input  NUM_CH  per-channel READY.
REQ-008 timeout_limit  input  CNT_W  stall cycles before timeout; 0 disables all channels.
REQ-009 clr  input  NUM_CH  per-channel write-1-to-clear pulse for sticky status.
REQ-010 irq_mask  input  NUM_CH  1 = channel excluded from interrupt.
REQ-011 timeout_sts  output  NUM_CH  sticky per-channel timeout flag, registered.
REQ-012 timeout_irq  output  1  interrupt, level.
REQ-013 first_vld  output  1  first-timeout record valid.
REQ-014 first_ch  output  4  index of first channel to time out.

Function
REQ-015 Channel i is stalled in a cycle iff en=1, timeout_limit!=0, valid[i]=1 and ready[i]=0.
REQ-016 Each channel SHALL run a 3-state FSM: IDLE, COUNT, EXPIRED.
REQ-017 IDLE->COUNT on stalled, with cnt loaded to 1; IDLE holds cnt=0 otherwise.
REQ-018 COUNT with stalled and cnt < timeout_limit-1: cnt increments by 1.
REQ-019 COUNT with stalled and cnt >= timeout_limit-1 (including limit lowered mid-count): ->EXPIRED and timeout_sts[i] set at that edge, so sts rises after exactly timeout_limit consecutive stalled cycles.
REQ-020 COUNT or EXPIRED with not stalled (handshake, valid low, en low, limit 0): ->IDLE, cnt=0.
REQ-021 EXPIRED holds cnt; no further set of timeout_sts[i] until the channel returns through IDLE.
REQ-022 clr[i]=1 clears timeout_sts[i]; a set and clr in the same cycle leave timeout_sts[i]=1.
REQ-023 A limit of 1 SHALL set sts at the edge ending the first stalled cycle (IDLE->EXPIRED directly).
REQ-024 cnt SHALL never wrap; width CNT_W, compared unsigned.
REQ-025 timeout_irq = OR over i of (timeout_sts[i] & ~irq_mask[i]), combinational from registered state.
REQ-026 en=0 SHALL not alter timeout_sts or first-timeout record.
REQ-027 Channels SHALL be independent; simultaneous events on several channels are processed in the same cycle.

Reset
REQ-028 On rst_n low: all FSMs IDLE, cnt=0, timeout_sts=0, timeout_irq=0, first_vld=0, first_ch=0, effective immediately.
REQ-029 Reset mid-count SHALL discard the count; counting restarts from 1 after release.

Configuration
REQ-030 Macro RSP_S2_DMA_WDOG_CAPTURE_EN defined: when first_vld=0 and any sts bit sets, first_vld<=1 and first_ch<=lowest-index setting channel; first_vld clears the cycle after timeout_sts becomes all zero.
REQ-031 Macro undefined: first_vld and first_ch tied to 0, no capture registers.

Structure
REQ-032 Shared package rsp_s2_dma_pkg SHALL hold the FSM state encoding (IDLE=2'd0, COUNT=2'd1, EXPIRED=2'd2) and the channel index constants CH_AW..CH_R.
REQ-033 Per-channel FSM/counter SHALL be sub-module rsp_s2_dma_axi_wdog_ch, instantiated NUM_CH times by generate.

Verification
REQ-034 limit=10, valid[1]=1 ready[1]=0 held -> timeout_sts[1] rises after 10 edges, irq=1 next combinational cycle; other bits 0.
REQ-035 limit=10, stall 9 cycles then ready=1 -> no sts; next stall 10 cycles -> sts set.
REQ-036 sts[0] set, clr[0] pulse while still stalled -> sts[0]=0 and stays 0 until handshake then 10 new stalled cycles.
REQ-037 Channels 3 and 1 expire same edge, CAPTURE_EN defined -> first_ch=1, first_vld=1; clear both -> first_vld=0.
REQ-038 irq_mask=5'b00100, only ch2 expires -> sts[2]=1, timeout_irq=0.
REQ-039 rst_n low at cnt=7 -> all outputs 0 asynchronously; after release a 10-cycle stall is required to set sts.
